// File: rtl/inst_fetch_apb_if.sv
// APB read-only bus between the fetch initiator and instruction memory.
// master: paddr/psel/penable/pwrite out, prdata/pready in; slave: reverse.
interface inst_fetch_apb_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       prdata;
  logic              pready;

  modport master (
    output paddr, psel, penable, pwrite,
    input  prdata, pready
  );

  modport slave (
    input  paddr, psel, penable, pwrite,
    output prdata, pready
  );
endinterface

// File: rtl/inst_fetch_apb.sv
// Instruction fetch: APB word reads split into 16-bit pairs for the buffer.
// Ports: clk, rst (async low), stall/branch in, apb master, inst1/inst2/write.
module inst_fetch_apb #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]     NOP      = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_flg,
  input  logic              branch_flg,
  input  logic [ADDR_W-1:0] branch_addr,
  inst_fetch_apb_if.master  apb,
  output logic [15:0]       inst1,
  output logic [15:0]       inst2,
  output logic              write
);

  typedef enum logic [1:0] {
    S_RST,
    S_SETUP,
    S_ACCESS,
    S_DELIVER
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_q, pend_d;
  logic              skip_q, skip_d;
  logic              deliver_q, deliver_d;
  logic [15:0]       inst1_q, inst1_d;
  logic [15:0]       inst2_q, inst2_d;

  // A branch seen in the final ACCESS cycle counts as pending.
  logic              redir;
  logic [ADDR_W-1:0] tgt;

  assign redir = branch_flg | pend_q;
  assign tgt   = branch_flg ? branch_addr : pend_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RST;
      pc_q        <= RESET_PC;
      pend_addr_q <= '0;
      pend_q      <= 1'b0;
      skip_q      <= 1'b0;
      deliver_q   <= 1'b0;
      inst1_q     <= '0;
      inst2_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      pend_q      <= pend_d;
      skip_q      <= skip_d;
      deliver_q   <= deliver_d;
      inst1_q     <= inst1_d;
      inst2_q     <= inst2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    pend_d      = pend_q;
    skip_d      = skip_q;
    inst1_d     = inst1_q;
    inst2_d     = inst2_q;
    unique case (state_q)
      S_RST: begin
        state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        if (branch_flg) begin
          pend_d      = 1'b1;
          pend_addr_d = branch_addr;
        end
      end
      S_ACCESS: begin
        if (branch_flg) begin
          pend_d      = 1'b1;
          pend_addr_d = branch_addr;
        end
        if (apb.pready) begin
          if (redir) begin
            pc_d    = {tgt[ADDR_W-1:2], 2'b00};
            skip_d  = tgt[1];
            pend_d  = 1'b0;
            state_d = S_SETUP;
          end else begin
            inst1_d = skip_q ? apb.prdata[31:16]
                             : apb.prdata[15:0];
            inst2_d = skip_q ? NOP
                             : apb.prdata[31:16];
            pc_d    = pc_q + ADDR_W'(4);
            state_d = S_DELIVER;
          end
        end
      end
      S_DELIVER: begin
        if (branch_flg) begin
          pc_d    = {branch_addr[ADDR_W-1:2], 2'b00};
          skip_d  = branch_addr[1];
          state_d = S_SETUP;
        end else if (!stall_flg) begin
          skip_d  = 1'b0;
          state_d = S_SETUP;
        end
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  assign deliver_d = (state_d == S_DELIVER);

  // paddr tracks the PC only while a transfer is addressed; during
  // DELIVER the PC already points past the word being handed over.
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (state_d == S_SETUP) begin
      addr_d = {pc_d[ADDR_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
    end else begin
      addr_q <= addr_d;
    end
  end

  assign apb.paddr   = addr_q;
  assign apb.psel    = (state_q == S_SETUP) ||
                       (state_q == S_ACCESS);
  assign apb.penable = (state_q == S_ACCESS);
  assign apb.pwrite  = 1'b0;

  assign inst1 = inst1_q;
  assign inst2 = inst2_q;
  assign write = deliver_q & ~branch_flg;

endmodule

// File: doc/inst_fetch_apb.md
# inst_fetch_apb

Instruction fetch initiator for the NanoQuarter core. Issues APB read transfers to instruction memory, one 32-bit word per transfer, and hands the two 16-bit halves to the prefetch buffer as an instruction pair on `inst1`/`inst2`, qualified by `write`. Holds each pair until the buffer accepts it (`write` high with `stall_flg` low). Also services branch redirects, including targets on an odd halfword.

## Interface
- `ADDR_W`, 16, byte-address width of `paddr` and the internal PC
- `RESET_PC`, 16'h0000, first fetch address after reset; bits [1:0] must be 0
- `NOP`, 16'h0000, encoding inserted in `inst2` after an odd-halfword branch target
- `clk`  input  1  system clock; all state updates on its rising edge
- `rst`  input  1  system reset, asynchronous, active-low
- `stall_flg`  input  1  buffer cannot accept; the held pair is not taken this cycle
- `branch_flg`  input  1  one-cycle redirect request
- `branch_addr`  input  ADDR_W  redirect byte address; bit 0 ignored
- `prdata`  input  32  APB read data; [15:0] is the lower-address instruction
- `pready`  input  1  APB completer ready
- `paddr`  output  ADDR_W  APB address, word aligned
- `psel`  output  1  APB select
- `penable`  output  1  APB enable
- `pwrite`  output  1  tied 0
- `inst1`  output  16  first instruction of the pair
- `inst2`  output  16  second instruction of the pair
- `write`  output  1  pair valid toward the prefetch buffer

## Operation
- The PC is a word-aligned byte address. `paddr` equals the PC with [1:0] = 00. The PC wraps from 2^ADDR_W−4 to 0.
- States:
  - RST: entered asynchronously while `rst`=0. Goes to SETUP on the first clock edge after release.
  - SETUP: `psel`=1, `penable`=0. Always goes to ACCESS on the next cycle.
  - ACCESS: `psel`=1, `penable`=1. Stays while `pready`=0. When `pready`=1:
    - If no redirect is pending: capture `prdata`, PC += 4, go to DELIVER.
    - If a redirect is pending: discard `prdata`, load the PC from the pending target, go to SETUP.
  - DELIVER: `psel`=0. Internal `deliver_q`=1.
    - The pair is accepted in a cycle where `write`=1 and `stall_flg`=0. On acceptance, go to SETUP.
    - Otherwise hold `inst1`/`inst2` stable and stay in DELIVER.
- `write` = `deliver_q` AND NOT `branch_flg`. This is the only combinational input-to-output path.
- Redirect (`branch_flg`=1):
  - In RST: ignored.
  - In DELIVER: the held pair is dropped. PC ← target, go to SETUP.
  - In SETUP or ACCESS: the APB transfer still completes, as protocol requires. The target is latched as pending and used at the end of ACCESS.
  - A newer `branch_flg` overwrites an older pending target.
- Odd-halfword target (`branch_addr[1]`=1):
  - The fetch is from the aligned word, with a `half_skip` flag set.
  - The delivered pair is `inst1` = `prdata[31:16]`, `inst2` = NOP.
  - `half_skip` clears on acceptance. The next fetch is word + 4.
- Normal pair: `inst1` = `prdata[15:0]`, `inst2` = `prdata[31:16]`.
- There is no `pslverr` handling. Read data is always taken as valid.

## Timing
- Reset values:
  - `psel`=0, `penable`=0, `pwrite`=0
  - `paddr`=RESET_PC
  - `inst1`=0, `inst2`=0, `write`=0
  - PC=RESET_PC, pending redirect cleared, `half_skip`=0
- A reset mid-transfer aborts immediately. `psel` drops asynchronously.
- The APB sequence is SETUP for exactly 1 cycle, then ACCESS for ≥1 cycle.
- `paddr` is stable from SETUP through the last ACCESS cycle.
- Minimum cadence with `pready`=1 and no stall is 3 cycles per pair (SETUP, ACCESS, DELIVER). `write` is high 1 cycle in every 3.
- `write` first rises 3 cycles after reset release with zero-wait memory.
- Latency from redirect in DELIVER to the target's SETUP is 1 cycle.
- Latency from redirect in SETUP/ACCESS is: remaining ACCESS cycles, plus 1 cycle to SETUP.
- `write` is never high in two consecutive cycles with `stall_flg`=0. This guarantees the buffer its 2-cycle drain.

## Test plan
- Reset release, RESET_PC=0, `pready`=1, memory words 0x11110000 @0 and 0x33332222 @4. Required:
  - `paddr`=0 in cycles 1–2, then `write`=1 in cycle 3 with `inst1`=0x0000, `inst2`=0x1111.
  - The next pair is 0x2222/0x3333 in cycle 6.
- `stall_flg`=1 for 4 cycles during DELIVER. Required: `write`=1 and `inst1`/`inst2` unchanged for all 4 cycles, and no new APB SETUP until the cycle after `stall_flg` falls.
- `pready` low for 3 ACCESS cycles. Required: `psel`=`penable`=1 and `paddr` stable for 3 cycles, then capture, then `write` on the next cycle.
- `branch_flg` with `branch_addr`=0x0042 during DELIVER. Required:
  - `write`=0 in that same cycle.
  - SETUP with `paddr`=0x0040 on the next cycle.
  - Delivered pair has `inst1`=`prdata[31:16]` and `inst2`=NOP.
  - The following fetch is at 0x0044.
- `branch_flg` to 0x0100 during a wait-stated ACCESS. Required: that transfer completes with no `write`, then SETUP at 0x0100.
- PC at 0xFFFC: after acceptance the next `paddr` is 0x0000. Separately, `rst` low mid-ACCESS forces `psel`=0 and `write`=0 asynchronously.
